// File: rtl/scratch_stack_ctrl_pkg.sv
// Shared CPU package: instruction opcode constants plus the scratch stack
// controller's command and FSM state encodings.
package scratch_stack_ctrl_pkg;

  // Base instruction opcodes (bits [6:0] of the instruction word).
  localparam logic [6:0] OpcodeLoad   = 7'b0000011;
  localparam logic [6:0] OpcodeStore  = 7'b0100011;
  localparam logic [6:0] OpcodeOpImm  = 7'b0010011;
  localparam logic [6:0] OpcodeCustom = 7'b0001011;

  // Stack commands issued by the execute stage.
  typedef enum logic [1:0] {
    OpNop   = 2'b00,
    OpPush  = 2'b01,
    OpPop   = 2'b10,
    OpClear = 2'b11
  } stack_op_e;

  // Controller FSM states.
  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StPushWr = 3'd1,
    StPopRd  = 3'd2,
    StPopOut = 3'd3,
    StFinish = 3'd4
  } stack_state_e;

endpackage

// File: rtl/stack_mem.sv
// Single-port stack storage: synchronous write, registered read.
// Written so it maps onto iCE40 block RAM.
// Ports:
//   clk   - clock
//   we    - write enable
//   addr  - cell address (shared by read and write)
//   wdata - write data
//   rdata - registered read data (old contents on a same-cycle write)
module stack_mem #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // No reset on the array or read register so block RAM inference holds.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/scratch_stack_ctrl.sv
// Scratch stack controller: executes PUSH/POP/CLEAR/NOP commands against a
// 2**ADDR_WIDTH-cell LIFO held in a single-port block RAM.
// Ports:
//   CLK, RST           - clock, asynchronous active-high reset
//   CMD_VALID/READY    - command handshake (READY only in idle)
//   CMD_OP, CMD_DATA   - command and push value, captured on accept
//   DONE, ERR          - one-cycle completion pulse; ERR flags over/underflow
//   POP_DATA           - last successfully popped value
//   SP, EMPTY, FULL    - cell count (0..2**ADDR_WIDTH) and its end flags
module scratch_stack_ctrl
  import scratch_stack_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  CMD_VALID,
  output logic                  CMD_READY,
  input  logic [1:0]            CMD_OP,
  input  logic [DATA_WIDTH-1:0] CMD_DATA,
  output logic                  DONE,
  output logic                  ERR,
  output logic [DATA_WIDTH-1:0] POP_DATA,
  output logic [ADDR_WIDTH:0]   SP,
  output logic                  EMPTY,
  output logic                  FULL
);

  localparam logic [ADDR_WIDTH:0] SpMax = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] SpOne = {{ADDR_WIDTH{1'b0}}, 1'b1};

  stack_state_e          state_q, state_d;
  logic [ADDR_WIDTH:0]   sp_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH-1:0] pop_data_q;
  logic                  done_q, err_q, err_pend_q;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_rdata;
  stack_op_e             op;
  logic                  accept, is_empty, is_full, cmd_err;

  assign op       = stack_op_e'(CMD_OP);
  assign is_empty = (sp_q == '0);
  assign is_full  = (sp_q == SpMax);
  assign accept   = CMD_VALID && CMD_READY;
  assign cmd_err  = ((op == OpPush) && is_full) || ((op == OpPop) && is_empty);

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          case (op)
            OpPush:  state_d = is_full  ? StFinish : StPushWr;
            OpPop:   state_d = is_empty ? StFinish : StPopRd;
            default: state_d = StFinish;
          endcase
        end
      end
      StPushWr: state_d = StIdle;
      StPopRd:  state_d = StPopOut;
      StPopOut: state_d = StIdle;
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // FSM outputs. READY is gated by RST so nothing is offered during reset.
  always_comb begin
    CMD_READY = (state_q == StIdle) && !RST;
    mem_we    = (state_q == StPushWr);
  end

  // Datapath. SP is decremented on pop accept so the memory address is
  // already the top cell during StPopRd, when the RAM registers its read.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sp_q       <= '0;
      data_q     <= '0;
      pop_data_q <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_pend_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        StIdle: begin
          if (accept) begin
            err_pend_q <= cmd_err;
            if ((op == OpPush) && !is_full) begin
              data_q <= CMD_DATA;
            end
            if ((op == OpPop) && !is_empty) begin
              sp_q <= sp_q - SpOne;
            end
            if (op == OpClear) begin
              sp_q <= '0;
            end
          end
        end
        StPushWr: begin
          sp_q   <= sp_q + SpOne;
          done_q <= 1'b1;
        end
        StPopOut: begin
          pop_data_q <= mem_rdata;
          done_q     <= 1'b1;
        end
        StFinish: begin
          done_q <= 1'b1;
          err_q  <= err_pend_q;
        end
        default: ;
      endcase
    end
  end

  stack_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_stack_mem (
    .clk  (CLK),
    .we   (mem_we),
    .addr (sp_q[ADDR_WIDTH-1:0]),
    .wdata(data_q),
    .rdata(mem_rdata)
  );

  assign DONE     = done_q;
  assign ERR      = err_q;
  assign POP_DATA = pop_data_q;
  assign SP       = sp_q;
  assign EMPTY    = is_empty;
  assign FULL     = is_full;

endmodule

// File: tb/tb_scratch_stack_ctrl.sv
// Directed self-checking bench for scratch_stack_ctrl.
module tb_scratch_stack_ctrl;

  localparam logic [1:0] NOP   = 2'b00;
  localparam logic [1:0] PUSH  = 2'b01;
  localparam logic [1:0] POP   = 2'b10;
  localparam logic [1:0] CLEAR = 2'b11;

  logic        CLK = 1'b0;
  logic        RST;
  logic        CMD_VALID;
  logic        CMD_READY;
  logic [1:0]  CMD_OP;
  logic [31:0] CMD_DATA;
  logic        DONE, ERR;
  logic [31:0] POP_DATA;
  logic [8:0]  SP;
  logic        EMPTY, FULL;

  int compared   = 0;
  int mismatched = 0;

  always #5 CLK = ~CLK;

  scratch_stack_ctrl #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(8)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .CMD_VALID(CMD_VALID),
    .CMD_READY(CMD_READY),
    .CMD_OP   (CMD_OP),
    .CMD_DATA (CMD_DATA),
    .DONE     (DONE),
    .ERR      (ERR),
    .POP_DATA (POP_DATA),
    .SP       (SP),
    .EMPTY    (EMPTY),
    .FULL     (FULL)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offer one command in idle and wait for DONE. Latency counts cycles with
  // the accept cycle as cycle 0, so DONE seen in cycle lat.
  task automatic issue(input logic [1:0] op, input logic [31:0] data,
                       input int exp_lat, input logic exp_err, input string tag);
    int lat;
    @(negedge CLK);
    chk({tag, ".ready"}, CMD_READY, 1);
    CMD_VALID = 1'b1;
    CMD_OP    = op;
    CMD_DATA  = data;
    @(posedge CLK);
    #1;
    CMD_VALID = 1'b0;
    CMD_OP    = NOP;
    lat       = 1;
    while (!DONE && lat < 10) begin
      chk({tag, ".busy_err_ready"}, {62'd0, ERR, CMD_READY}, 64'd0);
      @(posedge CLK);
      #1;
      lat++;
    end
    chk({tag, ".latency"}, lat, exp_lat);
    chk({tag, ".err"}, ERR, exp_err);
  endtask

  initial begin
    RST       = 1'b1;
    CMD_VALID = 1'b0;
    CMD_OP    = NOP;
    CMD_DATA  = '0;

    // Reset state.
    repeat (2) @(posedge CLK);
    #1;
    chk("rst.ready", CMD_READY, 0);
    chk("rst.sp", SP, 0);
    chk("rst.empty", EMPTY, 1);
    chk("rst.full", FULL, 0);
    chk("rst.done_err", {DONE, ERR}, 0);
    chk("rst.pop_data", POP_DATA, 0);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    chk("rst.ready_after", CMD_READY, 1);

    // Pop on empty.
    issue(POP, 32'h0, 2, 1'b1, "pop_empty");
    chk("pop_empty.sp", SP, 0);
    chk("pop_empty.pop_data", POP_DATA, 0);
    @(posedge CLK);
    #1;
    chk("pop_empty.done_one_cycle", {DONE, ERR}, 0);

    // LIFO order.
    issue(PUSH, 32'h11111111, 2, 1'b0, "push1");
    issue(PUSH, 32'h22222222, 2, 1'b0, "push2");
    issue(PUSH, 32'h33333333, 2, 1'b0, "push3");
    chk("lifo.sp3", SP, 3);
    issue(POP, 32'h0, 3, 1'b0, "pop3");
    chk("pop3.data", POP_DATA, 32'h33333333);
    issue(POP, 32'h0, 3, 1'b0, "pop2");
    chk("pop2.data", POP_DATA, 32'h22222222);
    issue(POP, 32'h0, 3, 1'b0, "pop1");
    chk("pop1.data", POP_DATA, 32'h11111111);
    chk("lifo.sp0", SP, 0);
    chk("lifo.empty", EMPTY, 1);

    // Push after pop overwrites the popped cell.
    issue(PUSH, 32'h44444444, 2, 1'b0, "repush");
    issue(POP, 32'h0, 3, 1'b0, "repop");
    chk("repop.data", POP_DATA, 32'h44444444);

    // NOP has no effect beyond DONE.
    issue(PUSH, 32'h55, 2, 1'b0, "nop_pre");
    issue(NOP, 32'hFFFFFFFF, 2, 1'b0, "nop");
    chk("nop.sp", SP, 1);
    chk("nop.pop_data", POP_DATA, 32'h44444444);

    // CLEAR.
    for (int i = 0; i < 4; i++) issue(PUSH, 32'h60 + i, 2, 1'b0, "clr_fill");
    chk("clr.sp5", SP, 5);
    issue(CLEAR, 32'h0, 2, 1'b0, "clear");
    chk("clear.sp", SP, 0);
    chk("clear.empty", EMPTY, 1);
    issue(POP, 32'h0, 2, 1'b1, "clear_pop");
    chk("clear_pop.sp", SP, 0);

    // Fill to full, overflow, pop.
    for (int i = 0; i < 256; i++) issue(PUSH, i, 2, 1'b0, "fill");
    chk("full.flag", FULL, 1);
    chk("full.sp", SP, 256);
    issue(PUSH, 32'hDEADBEEF, 2, 1'b1, "overflow");
    chk("overflow.sp", SP, 256);
    issue(POP, 32'h0, 3, 1'b0, "pop_full");
    chk("pop_full.data", POP_DATA, 255);
    chk("pop_full.sp", SP, 255);

    // Reset in the middle of a pop.
    issue(CLEAR, 32'h0, 2, 1'b0, "mid_clear");
    for (int i = 0; i < 4; i++) issue(PUSH, 32'h70 + i, 2, 1'b0, "mid_fill");
    @(negedge CLK);
    CMD_VALID = 1'b1;
    CMD_OP    = POP;
    @(posedge CLK);
    #1;
    CMD_VALID = 1'b0;
    CMD_OP    = NOP;
    chk("mid.sp_in_pop_rd", SP, 3);
    RST = 1'b1;
    #1;
    chk("mid.sp_reset", SP, 0);
    chk("mid.ready_in_reset", CMD_READY, 0);
    chk("mid.done_in_reset", DONE, 0);
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK);
    #1;
    chk("mid.ready_after", CMD_READY, 1);
    chk("mid.no_done1", DONE, 0);
    @(posedge CLK);
    #1;
    chk("mid.no_done2", DONE, 0);
    chk("mid.pop_data", POP_DATA, 0);
    issue(PUSH, 32'hA5, 2, 1'b0, "mid_push");
    issue(POP, 32'h0, 3, 1'b0, "mid_pop");
    chk("mid_pop.data", POP_DATA, 32'hA5);

    // CMD_VALID held high with back-to-back pushes: accept every other cycle.
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      if (i == 0) begin
        CMD_VALID = 1'b1;
        CMD_OP    = PUSH;
      end else begin
        chk("b2b.ready", CMD_READY, (i % 2 == 0) ? 1 : 0);
      end
      CMD_DATA = 32'h100 + i;
    end
    @(negedge CLK);
    CMD_VALID = 1'b0;
    CMD_OP    = NOP;
    chk("b2b.sp", SP, 6);
    issue(POP, 32'h0, 3, 1'b0, "b2b_pop");
    chk("b2b_pop.data", POP_DATA, 32'h10A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/scratch_stack_ctrl.md
SCRATCH_STACK_CTRL -- requirements
Module: scratch_stack_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, stack cell width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, log2 of stack depth (256 cells).
REQ-003 SHALL have port CLK, input, 1, sole clock, all state updates on rising edge.
REQ-004 SHALL have port RST, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port CMD_VALID, input, 1, command offered by the execute stage.
REQ-006 SHALL have port CMD_READY, output, 1, controller can accept a command this cycle.
REQ-007 SHALL have port CMD_OP, input, 2, command: 00 NOP, 01 PUSH, 10 POP, 11 CLEAR.
REQ-008 SHALL have port CMD_DATA, input, DATA_WIDTH, value to push.
REQ-009 SHALL have port DONE, output, 1, one-cycle completion pulse per accepted command.
REQ-010 SHALL have port ERR, output, 1, qualifies DONE: overflow or underflow.
REQ-011 SHALL have port POP_DATA, output, DATA_WIDTH, last successfully popped value.
REQ-012 SHALL have port SP, output, ADDR_WIDTH+1, current cell count (0..256).
REQ-013 SHALL have ports EMPTY and FULL, output, 1 each, SP==0 and SP==256 respectively.

Function
REQ-014 SHALL accept a command on any rising edge where CMD_VALID && CMD_READY; CMD_OP and CMD_DATA are captured at that edge.
REQ-015 SHALL use FSM states IDLE, PUSH_WR, POP_RD, POP_OUT, FINISH; CMD_READY = 1 only in IDLE.
REQ-016 PUSH, not full: IDLE->PUSH_WR; in PUSH_WR memory write enable is high at address SP[7:0] with captured data; at the next edge SP increments, DONE=1 with ERR=0 for the following cycle, return to IDLE.
REQ-017 POP, not empty: IDLE->POP_RD with SP decremented and read address SP-1 at the accept edge; POP_RD->POP_OUT (memory registered read); in POP_OUT the memory data is captured into POP_DATA at the edge that also raises DONE for one cycle; return to IDLE.
REQ-018 PUSH while FULL or POP while EMPTY: no memory write, SP unchanged, POP_DATA unchanged, IDLE->FINISH; DONE=1 and ERR=1 for one cycle, then IDLE.
REQ-019 CLEAR: SP<=0 at the accept edge, IDLE->FINISH; DONE=1, ERR=0; memory contents untouched.
REQ-020 NOP: IDLE->FINISH; DONE=1, ERR=0; no other effect.
REQ-021 Latency accept-to-DONE: PUSH 2 cycles, POP 3 cycles, all other outcomes 2 cycles; throughput of at most one command per latency window.
REQ-022 ERR SHALL be 0 whenever DONE is 0.
REQ-023 CMD_VALID may drop without acceptance; a non-accepted offer SHALL have no effect.
REQ-024 SP arithmetic SHALL be ADDR_WIDTH+1 bits and never wrap: SP stays within 0..256 under all command sequences.
REQ-025 A push after a pop SHALL overwrite the popped cell; a pop SHALL return the most recent unpopped push (LIFO).

Reset
REQ-026 On RST high the controller SHALL asynchronously enter IDLE with SP=0, DONE=0, ERR=0, POP_DATA=0, memory write enable=0.
REQ-027 RST asserted mid-command SHALL abandon that command with no DONE pulse and no further memory write; memory contents after reset are undefined.
REQ-028 While RST is high CMD_READY SHALL be 0; after RST deasserts, CMD_READY SHALL be 1 from the first clock edge.

Structure
REQ-029 Op encodings (NOP/PUSH/POP/CLEAR) and FSM state encodings SHALL live in the shared CPU package alongside the instruction opcode constants.
REQ-030 The storage SHALL be one sub-module, stack_mem: single-port, synchronous write, registered read, depth 2**ADDR_WIDTH, inferable as iCE40 block RAM.
REQ-031 The module SHALL contain no initial blocks; all initial state comes from RST.

Verification
REQ-032 Push 0x11111111, 0x22222222, 0x33333333, then 3 pops -> POP_DATA 0x33333333, 0x22222222, 0x11111111 on the respective DONE pulses; SP 3->0; EMPTY=1 at end.
REQ-033 Pop on empty after reset -> DONE=1/ERR=1 two cycles after accept, SP stays 0, POP_DATA stays 0.
REQ-034 Push 256 values i=0..255 -> FULL=1, SP=256; 257th push 0xDEADBEEF -> ERR=1; next pop returns 255.
REQ-035 Push 5 values, CLEAR -> SP=0, EMPTY=1, DONE/ERR=0; subsequent pop -> ERR=1.
REQ-036 Assert RST in POP_RD of a pop with SP=4 -> no DONE, SP=0, CMD_READY=1 after the first post-reset edge; push 0xA5 then pop -> 0xA5.
REQ-037 Hold CMD_VALID high with back-to-back PUSHes -> exactly one accept per 2-cycle window; CMD_READY=0 in PUSH_WR and on every non-IDLE cycle.
